// File: rtl/stack_ctrl.sv
// Self-managing LIFO controller with push/pop/replace commands, a combinational top
// entry, and sticky overflow/underflow flags. Define STACK_WRAP_EN for the circular variant.
module stack_ctrl #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             active_low_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear_error,
   output logic [WIDTH-1:0] top_data,
   output logic [DEPTH:0]   count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   localparam int             CAP     = 2**DEPTH;
   localparam logic [DEPTH:0] CAP_CNT = (DEPTH+1)'(CAP);
   localparam logic [DEPTH:0] CNT_ONE = 1;
   localparam logic [DEPTH-1:0] SP_ONE = 1;

   logic [WIDTH-1:0] mem [CAP];
   logic [DEPTH-1:0] sp, sp_top, wr_addr;
   logic             do_push, do_pop, do_rep;
   logic             push_ok, pop_ok, grow, unf_evt, wr_en;

   assign sp_top   = sp - SP_ONE;
   assign empty    = (count == '0);
   assign full     = (count == CAP_CNT);
   assign top_data = empty ? '0 : mem[sp_top];

   // Replace on an empty stack has nothing to overwrite, so it degrades to a plain push.
   always_comb begin
      do_push = push & (~pop | empty);
      do_rep  = push & pop & ~empty;
      do_pop  = pop & ~push;
      pop_ok  = do_pop & ~empty;
      unf_evt = do_pop & empty;
`ifdef STACK_WRAP_EN
      push_ok = do_push;
`else
      push_ok = do_push & ~full;
`endif
      grow    = push_ok & ~full;
      wr_en   = push_ok | do_rep;
      wr_addr = do_rep ? sp_top : sp;
   end

   // Storage is not reset; writes are still suppressed while reset is held.
   always_ff @(posedge clock) begin
      if (wr_en && active_low_reset)
         mem[wr_addr] <= push_data;
   end

   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         sp        <= '0;
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         if (push_ok)
            sp <= sp + SP_ONE;
         else if (pop_ok)
            sp <= sp_top;
         if (grow)
            count <= count + CNT_ONE;
         else if (pop_ok)
            count <= count - CNT_ONE;
         if (unf_evt)
            underflow <= 1'b1;
         else if (clear_error)
            underflow <= 1'b0;
      end
   end

`ifdef STACK_WRAP_EN
   assign overflow = 1'b0;
`else
   logic ovf_evt;
   assign ovf_evt = do_push & full;

   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset)
         overflow <= 1'b0;
      else if (ovf_evt)
         overflow <= 1'b1;
      else if (clear_error)
         overflow <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (WIDTH=16, DEPTH=2): directed vector table, async-reset sequence,
// then random traffic against a queue-based model of the stack.
module tb_stack_ctrl;
   localparam int WIDTH = 16;
   localparam int DEPTH = 2;
   localparam int CAP   = 4;
`ifdef STACK_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             active_low_reset;
   logic             push, pop, clear_error;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] top_data;
   logic [DEPTH:0]   count;
   logic             empty, full, overflow, underflow;

   stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock            (clock),
      .active_low_reset (active_low_reset),
      .push             (push),
      .push_data        (push_data),
      .pop              (pop),
      .clear_error      (clear_error),
      .top_data         (top_data),
      .count            (count),
      .empty            (empty),
      .full             (full),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   always #5 clock = ~clock;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        p, o, c;
      logic [15:0] d;
      int          cnt;
      logic [15:0] top;
      logic        ovf, unf;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic p, input logic o, input logic c, input logic [15:0] d,
                      input int cnt, input logic [15:0] top, input logic ovf, input logic unf);
      vec_t v;
      v.p = p; v.o = o; v.c = c; v.d = d; v.cnt = cnt; v.top = top; v.ovf = ovf; v.unf = unf;
      tbl.push_back(v);
   endtask

   // Reference model: the stack as a queue, newest entry at the back.
   logic [15:0] q[$];
   logic        m_ovf, m_unf;

   task automatic model_apply(input logic p, input logic o, input logic c, input logic [15:0] d);
      logic ev_o, ev_u;
      ev_o = 1'b0; ev_u = 1'b0;
      if (p && !o) begin
         if (q.size() < CAP) q.push_back(d);
         else if (WRAP) begin void'(q.pop_front()); q.push_back(d); end
         else ev_o = 1'b1;
      end else if (o && !p) begin
         if (q.size() == 0) ev_u = 1'b1;
         else void'(q.pop_back());
      end else if (p && o) begin
         if (q.size() == 0) q.push_back(d);
         else q[q.size()-1] = d;
      end
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (ev_o) m_ovf = 1'b1;
      if (ev_u) m_unf = 1'b1;
   endtask

   task automatic step(input logic p, input logic o, input logic c, input logic [15:0] d);
      push = p; pop = o; clear_error = c; push_data = d;
      @(posedge clock);
      model_apply(p, o, c, d);
      @(negedge clock);
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic [15:0] top,
                            input logic ovf, input logic unf);
      chk({tag, " count"},     32'(count),     32'(cnt));
      chk({tag, " top"},       32'(top_data),  32'(top));
      chk({tag, " empty"},     32'(empty),     32'(cnt == 0));
      chk({tag, " full"},      32'(full),      32'(cnt == CAP));
      chk({tag, " overflow"},  32'(overflow),  32'(ovf));
      chk({tag, " underflow"}, 32'(underflow), 32'(unf));
   endtask

   task automatic chk_model(input string tag);
      chk_state(tag, q.size(), (q.size() == 0) ? 16'h0 : q[q.size()-1], m_ovf, m_unf);
   endtask

   initial begin
      active_low_reset = 1'b0;
      push = 1'b0; pop = 1'b0; clear_error = 1'b0; push_data = '0;
      m_ovf = 1'b0; m_unf = 1'b0;

      @(negedge clock);
      chk_state("reset", 0, 16'h0, 1'b0, 1'b0);
      active_low_reset = 1'b1;

      // Async reset mid-run: outputs drop without waiting for a clock edge.
      step(1, 0, 0, 16'h1111);
      step(1, 0, 0, 16'h2222);
      chk_state("pre-reset", 2, 16'h2222, 1'b0, 1'b0);
      #2 active_low_reset = 1'b0;
      #1 chk_state("async reset", 0, 16'h0, 1'b0, 1'b0);
      push = 1'b1; push_data = 16'h3333;
      @(posedge clock); @(negedge clock);
      chk_state("push in reset", 0, 16'h0, 1'b0, 1'b0);
      push = 1'b0;
      active_low_reset = 1'b1;

      // Fill/drain
      add(1,0,0,16'hA001, 1,16'hA001,0,0);
      add(1,0,0,16'hA002, 2,16'hA002,0,0);
      add(1,0,0,16'hA003, 3,16'hA003,0,0);
      add(1,0,0,16'hA004, 4,16'hA004,0,0);
      add(0,1,0,16'h0000, 3,16'hA003,0,0);
      add(0,1,0,16'h0000, 2,16'hA002,0,0);
      add(0,1,0,16'h0000, 1,16'hA001,0,0);
      add(0,1,0,16'h0000, 0,16'h0000,0,0);
      // Underflow and clear priority
      add(0,1,0,16'h0000, 0,16'h0000,0,1);
      add(0,1,1,16'h0000, 0,16'h0000,0,1);
      add(0,0,1,16'h0000, 0,16'h0000,0,0);
      // Replace, including replace on empty
      add(1,0,0,16'h1111, 1,16'h1111,0,0);
      add(1,0,0,16'hBEEF, 2,16'hBEEF,0,0);
      add(1,1,0,16'h1234, 2,16'h1234,0,0);
      add(0,1,0,16'h0000, 1,16'h1111,0,0);
      add(0,1,0,16'h0000, 0,16'h0000,0,0);
      add(1,1,0,16'h5555, 1,16'h5555,0,0);
      add(0,1,0,16'h0000, 0,16'h0000,0,0);
      // Push while full
      add(1,0,0,16'hA001, 1,16'hA001,0,0);
      add(1,0,0,16'hA002, 2,16'hA002,0,0);
      add(1,0,0,16'hA003, 3,16'hA003,0,0);
      add(1,0,0,16'hA004, 4,16'hA004,0,0);
      add(1,1,0,16'hA00F, 4,16'hA00F,0,0);
      add(1,1,0,16'hA004, 4,16'hA004,0,0);
      add(1,0,0,16'hA005, 4, WRAP ? 16'hA005 : 16'hA004, !WRAP, 0);
      add(0,1,0,16'h0000, 3, WRAP ? 16'hA004 : 16'hA003, !WRAP, 0);
      add(0,1,0,16'h0000, 2, WRAP ? 16'hA003 : 16'hA002, !WRAP, 0);
      add(0,1,0,16'h0000, 1, WRAP ? 16'hA002 : 16'hA001, !WRAP, 0);
      add(0,1,0,16'h0000, 0, 16'h0000, !WRAP, 0);
      add(0,1,1,16'h0000, 0, 16'h0000, 0, 1);
      add(0,0,1,16'h0000, 0, 16'h0000, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].p, tbl[i].o, tbl[i].c, tbl[i].d);
         chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].ovf, tbl[i].unf);
      end

      // Random traffic vs. model, starting from a fresh reset.
      @(negedge clock);
      active_low_reset = 1'b0;
      #1 active_low_reset = 1'b1;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      for (int n = 0; n < 600; n++) begin
         int r, bias;
         logic p, o, c;
         bias = (n % 200 < 100) ? 7 : 3;
         r = $urandom_range(0, 9);
         p = (r < bias);
         o = ($urandom_range(0, 9) >= bias) || (r == 9);
         c = ($urandom_range(0, 15) == 0);
         step(p, o, c, 16'($urandom));
         chk_model($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
